// File: rtl/a_to_b_delay_gen.sv
// a_to_b_delay_gen: every accepted trigger on `a` yields one `b` pulse
// exactly DELAY clock edges later.
// Overlapping triggers are queued as 8-bit timestamps in a small FIFO.
// Define A2B_DELAY_SVA_EN to compile in the embedded assertions and covers.
module a_to_b_delay_gen #(
    parameter int DELAY = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a,
    output logic                       b,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       full,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0]    DLY     = 8'(DELAY);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    tick_reg;
    logic [7:0]    mem_reg [DEPTH];
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic          b_reg, full_reg, overflow_reg;

    logic [7:0]    age;
    logic          pop, room, push, drop, fresh_head;
    logic [PW-1:0] head_next, tail_next;
    logic [CW-1:0] count_next;
    logic [7:0]    tick_next, head_ts_next, age_next;
    logic          b_next;

    // Pop/push decisions for this edge, plus a look-ahead of whether the
    // head after this edge matures on the next edge.
    // `b` is loaded one edge early so it is visible at the maturing edge
    // while still coming straight from a flop.
    always_comb begin
        age          = tick_reg - mem_reg[head_reg];
        pop          = (count_reg != '0) && (age == DLY);
        room         = (count_reg != DEPTH_C) || pop;
        push         = a && room;
        drop         = a && !room;
        head_next    = pop  ? head_reg + PW'(1) : head_reg;
        tail_next    = push ? tail_reg + PW'(1) : tail_reg;
        count_next   = count_reg + CW'(push) - CW'(pop);
        tick_next    = tick_reg + 8'd1;
        // A trigger pushed into a FIFO that is empty after the pop becomes
        // the new head; its timestamp is not in the array yet.
        fresh_head   = push && (count_reg == CW'(pop));
        head_ts_next = fresh_head ? tick_reg : mem_reg[head_next];
        age_next     = tick_next - head_ts_next;
        b_next       = (count_next != '0) && (age_next == DLY);
    end

    // Timestamp storage, one write-enabled register per entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            // Capture the current tick when this entry is the push target.
            always_ff @(posedge clk) begin
                if (!rst && push && (tail_reg == PW'(gi))) begin
                    mem_reg[gi] <= tick_reg;
                end
            end
        end
    endgenerate

    // Tick counter, FIFO pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg     <= 8'd0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            b_reg        <= 1'b0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            tick_reg  <= tick_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            b_reg     <= b_next;
            full_reg  <= (count_next == DEPTH_C);
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign b        = b_reg;
    assign pending  = count_reg;
    assign full     = full_reg;
    assign overflow = overflow_reg;

`ifdef A2B_DELAY_SVA_EN
    a_to_b_latency: assert property (@(posedge clk) disable iff (rst)
        (a && (!full || b)) |-> ##DELAY b);

    b_has_cause: assert property (@(posedge clk) disable iff (rst)
        b |-> $past(a, DELAY));

    generate
        if (DEPTH >= DELAY) begin : g_no_ovf
            no_overflow: assert property (@(posedge clk) disable iff (rst)
                !overflow);
        end
    endgenerate

    cover_a_to_b: cover property (@(posedge clk) disable iff (rst)
        a ##DELAY b);

    cover_full: cover property (@(posedge clk) disable iff (rst)
        full);
`endif

endmodule

// File: doc/a_to_b_delay_gen.md
# a_to_b_delay_gen

- Upstream stimulus stage for the delay-operator sequence checks.
- Each `a` pulse accepted on an input edge produces exactly one `b` pulse exactly `DELAY` clock edges later, which is the `a ##DELAY b` relation the downstream cover targets.
- Overlapping triggers are buffered in a small timestamp FIFO, so trains of `a` pulses are reproduced as `b` trains with the same spacing.
- Occupancy and loss are reported to the bench.

## Interface

Parameters:
- `DELAY`, default 3 — trigger-to-`b` latency in clock edges; legal range 1..255.
- `DEPTH`, default 4 — FIFO entries, i.e. max outstanding triggers; power of two, ≥2.

Ports:
- `clk`  in  1  — single clock; all logic on posedge.
- `rst`  in  1  — synchronous, active-high reset.
- `a`  in  1  — trigger, sampled every posedge.
- `b`  out  1  — registered delayed pulse.
- `pending`  out  $clog2(DEPTH+1)  — number of accepted triggers whose `b` has not yet been issued.
- `full`  out  1  — `pending == DEPTH`.
- `overflow`  out  1  — sticky: a trigger was dropped.

## Operation

- Free-running 8-bit `tick` counter increments every cycle, wrapping 255→0.
- **Push:** `a=1` at an edge with `rst=0` and a free slot.
  - The edge's `tick` is written at the FIFO tail.
  - `pending` increments.
- **Pop:** the head entry matures when `(tick - head) mod 256 == DELAY` at the edge where `b` must be seen.
  - `b` is driven 1 for exactly that one cycle.
  - The entry is removed and `pending` decrements.
  - Only the head can mature; entries are strictly age-ordered, so at most one pop per cycle.
- **Push and pop on the same edge:** both occur and `pending` is unchanged.
  - A push while `full` is accepted if a pop happens on the same edge.
- **Overflow:** `a=1` while `full` and no same-edge pop.
  - The trigger is dropped and no `b` is ever produced for it.
  - `overflow` is set and held until `rst`.
- With `DEPTH ≥ DELAY`, overflow is impossible.
- Modulo-256 age arithmetic is exact because no entry is older than `DELAY ≤ 255`.
- **Reset** (`rst=1` at an edge):
  - `tick=0`, FIFO emptied, `pending=0`, `full=0`, `overflow=0`, `b=0`.
  - `a` sampled on a reset edge is ignored.
  - In-flight triggers are discarded and produce no `b`.

## Timing

- `a=1` sampled at edge t (accepted) → `b=1` sampled at edge t+DELAY, and `b=0` at t+DELAY+1 unless another trigger matures.
- `DELAY=1`: `b` is `a` registered by one cycle.
- `b` is a flop output; no combinational path from `a` to `b`.
- `pending`, `full` and `overflow` are registered and reflect state after the edge.
- `overflow` rises one cycle after the dropping edge.
- All outputs are 0 from the first edge with `rst=1` through the first edge after `rst` falls, except that a trigger accepted on that first edge is processed normally.

## Configuration

- `A2B_DELAY_SVA_EN` defined compiles in embedded properties, all with `disable iff (rst)`:
  - assert `a && (!full || b) |-> ##DELAY b`;
  - assert `b |-> $past(a, DELAY)`;
  - assert `!overflow` when `DEPTH >= DELAY`;
  - cover `a ##DELAY b`;
  - cover `full`.
- Undefined: pure RTL, no properties. Port list and behaviour are identical either way.

## Test plan

- **Single pulse:** `DELAY=3`, `a=1` only at edge 5 → `b=1` only at edge 8; `pending` is 1 after edges 5–7 and 0 after edge 8.
- **Back-to-back:** `DELAY=3`, `DEPTH=4`, `a=1` at edges 10–13 → `b=1` at edges 13–16; `pending` peaks at 3; `full` and `overflow` stay 0.
- **Overflow:** `DELAY=8`, `DEPTH=4`, `a=1` at edges 20–25.
  - Triggers at 20–23 are accepted; 24 and 25 are dropped.
  - `b=1` at edges 28–31 only.
  - `overflow=1` from edge 25 onward; `full=1` after edges 23–27.
- **Wrap-around:** `DELAY=5`, run 300 cycles, `a=1` at `tick=253` → `b=1` at `tick=2`, exactly 5 edges later.
- **Reset mid-flight:** `DELAY=4`, `a=1` at edges 3 and 4, `rst=1` at edge 5, `a=1` at edge 6.
  - `b` is never 1 at edges 7 or 8.
  - `b=1` at edge 10.
  - `pending=0` after edge 5.
- **Minimum delay:** `DELAY=1`, `a` pattern 1,0,1,1 at edges 2–5 → `b` pattern 1,0,1,1 at edges 3–6.
